// File: rtl/ovl_fire_pkg.sv
// rtl/ovl_fire_pkg.sv - shared fire-vector constants and event record for the OVL fire collector
package ovl_fire_pkg;

    localparam int FIRE_2STATE = 0;
    localparam int FIRE_XCHECK = 1;
    localparam int FIRE_COVER  = 2;
    localparam int FIRE_WIDTH  = 3;

    localparam logic [1:0] EVT_FAIL  = 2'b01;
    localparam logic [1:0] EVT_XFAIL = 2'b10;
    localparam logic [1:0] EVT_BOTH  = 2'b11;

    // Fixed-width fields cover up to 64 checkers and 32-bit timestamps.
    localparam int EVT_IDX_W  = 6;
    localparam int EVT_TIME_W = 32;

    typedef struct packed {
        logic [EVT_IDX_W-1:0]  index;
        logic [1:0]            etype;
        logic                  multi;
`ifdef OVL_FIRE_COLLECTOR_TIMESTAMP_EN
        logic [EVT_TIME_W-1:0] tstamp;
`endif
    } fire_evt_t;

endpackage

// File: rtl/ovl_fire_fifo.sv
// rtl/ovl_fire_fifo.sv - synchronous event FIFO with flush, extra-bit pointers for full/empty
module ovl_fire_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             valid,
    output logic             full
);

    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (wr_ptr != rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && valid;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ovl_fire_collector.sv
// rtl/ovl_fire_collector.sv - aggregates OVL fire vectors into sticky flags, counters, event FIFO, irq
// Optional event timestamps: OVL_FIRE_COLLECTOR_TIMESTAMP_EN
module ovl_fire_collector
    import ovl_fire_pkg::*;
#(
    parameter int num_checkers = 4,
    parameter int cnt_width    = 16,
    parameter int fifo_depth   = 4,
    localparam int IDX_W = (num_checkers > 1) ? $clog2(num_checkers) : 1,
    localparam int PC_W  = $clog2(num_checkers + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [num_checkers*FIRE_WIDTH-1:0] fire_in,
    input  logic                             clear,
    output logic [num_checkers-1:0]          sticky_fail,
    output logic [num_checkers-1:0]          sticky_xfail,
    output logic [cnt_width-1:0]             fail_count,
    output logic [cnt_width-1:0]             cover_count,
    output logic                             evt_valid,
    input  logic                             evt_ready,
    output logic [IDX_W-1:0]                 evt_index,
    output logic [1:0]                       evt_type,
    output logic                             evt_multi,
`ifdef OVL_FIRE_COLLECTOR_TIMESTAMP_EN
    output logic [cnt_width-1:0]             evt_time,
`endif
    output logic                             overflow,
    output logic                             irq
);

    logic                    sample;
    logic [num_checkers-1:0] fail_vec;
    logic [num_checkers-1:0] xfail_vec;
    logic [num_checkers-1:0] cover_vec;
    logic [num_checkers-1:0] failing;
    logic [PC_W-1:0]         fail_pc;
    logic [PC_W-1:0]         cover_pc;
    logic [IDX_W-1:0]        low_idx;
    logic [cnt_width:0]      fail_sum;
    logic [cnt_width:0]      cover_sum;

    logic [num_checkers-1:0] sticky_fail_nxt;
    logic [num_checkers-1:0] sticky_xfail_nxt;
    logic [cnt_width-1:0]    fail_count_nxt;
    logic [cnt_width-1:0]    cover_count_nxt;
    logic                    overflow_nxt;

    fire_evt_t               new_evt;
    fire_evt_t               head_evt;
    logic                    push;
    logic                    fifo_valid;
    logic                    fifo_full;
    logic                    unused_head;

    assign sample = enable && !clear;

`ifdef OVL_FIRE_COLLECTOR_TIMESTAMP_EN
    logic [cnt_width-1:0] ts_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     ts_cnt <= '0;
        else if (clear) ts_cnt <= '0;
        else            ts_cnt <= ts_cnt + cnt_width'(1);
    end
`endif

    always_comb begin
        fail_vec  = '0;
        xfail_vec = '0;
        cover_vec = '0;
        fail_pc   = '0;
        cover_pc  = '0;
        low_idx   = '0;
        for (int k = 0; k < num_checkers; k++) begin
            fail_vec[k]  = fire_in[FIRE_WIDTH*k + FIRE_2STATE];
            xfail_vec[k] = fire_in[FIRE_WIDTH*k + FIRE_XCHECK];
            cover_vec[k] = fire_in[FIRE_WIDTH*k + FIRE_COVER];
        end
        failing = fail_vec | xfail_vec;
        for (int k = 0; k < num_checkers; k++) begin
            fail_pc  = fail_pc + PC_W'(failing[k]);
            cover_pc = cover_pc + PC_W'(cover_vec[k]);
        end
        // Descending scan leaves the lowest failing index in low_idx.
        for (int k = num_checkers - 1; k >= 0; k--) begin
            if (failing[k]) low_idx = IDX_W'(k);
        end
    end

    always_comb begin
        new_evt       = '0;
        new_evt.index = EVT_IDX_W'(low_idx);
        new_evt.etype = {xfail_vec[low_idx], fail_vec[low_idx]};
        new_evt.multi = (fail_pc > PC_W'(1));
`ifdef OVL_FIRE_COLLECTOR_TIMESTAMP_EN
        new_evt.tstamp = EVT_TIME_W'(ts_cnt);
`endif
    end

    assign push      = sample && (|failing);
    assign fail_sum  = {1'b0, fail_count} + (cnt_width+1)'(fail_pc);
    assign cover_sum = {1'b0, cover_count} + (cnt_width+1)'(cover_pc);

    always_comb begin
        sticky_fail_nxt  = sticky_fail;
        sticky_xfail_nxt = sticky_xfail;
        fail_count_nxt   = fail_count;
        cover_count_nxt  = cover_count;
        overflow_nxt     = overflow;
        if (clear) begin
            sticky_fail_nxt  = '0;
            sticky_xfail_nxt = '0;
            fail_count_nxt   = '0;
            cover_count_nxt  = '0;
            overflow_nxt     = 1'b0;
        end else if (sample) begin
            sticky_fail_nxt  = sticky_fail | fail_vec;
            sticky_xfail_nxt = sticky_xfail | xfail_vec;
            fail_count_nxt   = fail_sum[cnt_width] ? '1 : fail_sum[cnt_width-1:0];
            cover_count_nxt  = cover_sum[cnt_width] ? '1 : cover_sum[cnt_width-1:0];
            if (push && fifo_full && !evt_ready) overflow_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sticky_fail  <= '0;
            sticky_xfail <= '0;
            fail_count   <= '0;
            cover_count  <= '0;
            overflow     <= 1'b0;
            irq          <= 1'b0;
        end else begin
            sticky_fail  <= sticky_fail_nxt;
            sticky_xfail <= sticky_xfail_nxt;
            fail_count   <= fail_count_nxt;
            cover_count  <= cover_count_nxt;
            overflow     <= overflow_nxt;
            irq          <= (|sticky_fail_nxt) || (|sticky_xfail_nxt) || overflow_nxt;
        end
    end

    ovl_fire_fifo #(
        .width ($bits(fire_evt_t)),
        .depth (fifo_depth)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (clear),
        .push      (push),
        .push_data (new_evt),
        .pop       (evt_ready && !clear),
        .head      (head_evt),
        .valid     (fifo_valid),
        .full      (fifo_full)
    );

    // Head fields read as zero while empty so the unwritten storage never leaks out.
    assign evt_valid   = fifo_valid;
    assign evt_index   = fifo_valid ? head_evt.index[IDX_W-1:0] : '0;
    assign evt_type    = fifo_valid ? head_evt.etype : 2'b00;
    assign evt_multi   = fifo_valid && head_evt.multi;
`ifdef OVL_FIRE_COLLECTOR_TIMESTAMP_EN
    assign evt_time    = fifo_valid ? head_evt.tstamp[cnt_width-1:0] : '0;
`endif
    assign unused_head = ^head_evt;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// tb/tb_ovl_fire_collector.sv - vector table, directed corners and randomized model check for ovl_fire_collector
module tb_ovl_fire_collector;

    localparam int N  = 4;
    localparam int CW = 4;
    localparam int D  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            enable = 1'b0;
    logic [3*N-1:0]  fire_in = '0;
    logic            clear = 1'b0;
    logic [N-1:0]    sticky_fail;
    logic [N-1:0]    sticky_xfail;
    logic [CW-1:0]   fail_count;
    logic [CW-1:0]   cover_count;
    logic            evt_valid;
    logic            evt_ready = 1'b0;
    logic [1:0]      evt_index;
    logic [1:0]      evt_type;
    logic            evt_multi;
    logic            overflow;
    logic            irq;
`ifdef OVL_FIRE_COLLECTOR_TIMESTAMP_EN
    logic [CW-1:0]   evt_time;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ovl_fire_collector #(.num_checkers(N), .cnt_width(CW), .fifo_depth(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .fire_in      (fire_in),
        .clear        (clear),
        .sticky_fail  (sticky_fail),
        .sticky_xfail (sticky_xfail),
        .fail_count   (fail_count),
        .cover_count  (cover_count),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_index    (evt_index),
        .evt_type     (evt_type),
        .evt_multi    (evt_multi),
`ifdef OVL_FIRE_COLLECTOR_TIMESTAMP_EN
        .evt_time     (evt_time),
`endif
        .overflow     (overflow),
        .irq          (irq)
    );

    typedef struct {
        int idx;
        int typ;
        int mul;
        int ts;
    } mev_t;

    int   m_sf[N];
    int   m_sxf[N];
    int   m_fc;
    int   m_cc;
    int   m_ovf;
    int   m_irq;
    int   m_ts;
    mev_t m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int flags_of(input int f[N]);
        int r = 0;
        for (int k = 0; k < N; k++) if (f[k] != 0) r += (1 << k);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_sf[k]  = 0;
            m_sxf[k] = 0;
        end
        m_fc = 0; m_cc = 0; m_ovf = 0; m_irq = 0; m_ts = 0;
        m_q.delete();
    endtask

    task automatic model_step(input bit en, input logic [3*N-1:0] fire, input bit clr, input bit rdy);
        int nf, nc, first, v;
        if (clr) begin
            model_reset();
            return;
        end
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (en) begin
            nf = 0; nc = 0; first = -1;
            for (int k = 0; k < N; k++) begin
                v = int'((fire >> (3 * k)) & 7);
                if (v & 1) m_sf[k] = 1;
                if (v & 2) m_sxf[k] = 1;
                if (v & 4) nc++;
                if (v & 3) begin
                    nf++;
                    if (first < 0) first = k;
                end
            end
            m_fc = (m_fc + nf > CMAX) ? CMAX : m_fc + nf;
            m_cc = (m_cc + nc > CMAX) ? CMAX : m_cc + nc;
            if (nf > 0) begin
                if (m_q.size() < D)
                    m_q.push_back('{first, int'((fire >> (3 * first)) & 3), (nf > 1) ? 1 : 0, m_ts});
                else
                    m_ovf = 1;
            end
        end
        m_ts = (m_ts + 1) % (CMAX + 1);
        m_irq = (flags_of(m_sf) != 0 || flags_of(m_sxf) != 0 || m_ovf != 0) ? 1 : 0;
    endtask

    task automatic check_model();
        mev_t h = '{0, 0, 0, 0};
        int   v = (m_q.size() > 0) ? 1 : 0;
        if (v != 0) h = m_q[0];
        chk("sticky_fail",  32'(sticky_fail),  flags_of(m_sf));
        chk("sticky_xfail", 32'(sticky_xfail), flags_of(m_sxf));
        chk("fail_count",   32'(fail_count),   m_fc);
        chk("cover_count",  32'(cover_count),  m_cc);
        chk("evt_valid",    32'(evt_valid),    v);
        chk("evt_index",    32'(evt_index),    h.idx);
        chk("evt_type",     32'(evt_type),     h.typ);
        chk("evt_multi",    32'(evt_multi),    h.mul);
        chk("overflow",     32'(overflow),     m_ovf);
        chk("irq",          32'(irq),          m_irq);
`ifdef OVL_FIRE_COLLECTOR_TIMESTAMP_EN
        chk("evt_time",     32'(evt_time),     h.ts);
`endif
    endtask

    // Called at a falling edge: drive, clock once, advance the model, settle to the next falling edge.
    task automatic cycle(input bit en, input logic [3*N-1:0] fire, input bit clr, input bit rdy);
        enable = en; fire_in = fire; clear = clr; evt_ready = rdy;
        @(posedge clock);
        model_step(en, fire, clr, rdy);
        @(negedge clock);
    endtask

    typedef struct {
        bit          en;
        logic [11:0] fire;
        bit          clr;
        bit          rdy;
        logic [3:0]  sf;
        logic [3:0]  sxf;
        logic [3:0]  fc;
        logic [3:0]  cc;
        bit          v;
        logic [1:0]  idx;
        logic [1:0]  typ;
        bit          mul;
        bit          ovf;
        bit          irq;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // en fire clr rdy | sf sxf fc cc | v idx typ mul ovf irq
        tbl.push_back(vec_t'{1, 12'h040, 0, 0, 4'b0100, 4'b0000, 4'd1, 4'd0, 1, 2'd2, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b0100, 4'b0000, 4'd1, 4'd0, 0, 2'd0, 2'b00, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h408, 0, 0, 4'b0110, 4'b1000, 4'd3, 4'd0, 1, 2'd1, 2'b01, 1, 0, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b0110, 4'b1000, 4'd3, 4'd0, 0, 2'd0, 2'b00, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h001, 0, 0, 4'b0111, 4'b1000, 4'd4, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h010, 0, 0, 4'b0111, 4'b1010, 4'd5, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h0C0, 0, 0, 4'b0111, 4'b1110, 4'd6, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h200, 0, 0, 4'b1111, 4'b1110, 4'd7, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h002, 0, 0, 4'b1111, 4'b1111, 4'd8, 4'd0, 1, 2'd0, 2'b01, 0, 1, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b1111, 4'b1111, 4'd8, 4'd0, 1, 2'd1, 2'b10, 0, 1, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b1111, 4'b1111, 4'd8, 4'd0, 1, 2'd2, 2'b11, 0, 1, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b1111, 4'b1111, 4'd8, 4'd0, 1, 2'd3, 2'b01, 0, 1, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b1111, 4'b1111, 4'd8, 4'd0, 0, 2'd0, 2'b00, 0, 1, 1});
        tbl.push_back(vec_t'{1, 12'h001, 1, 0, 4'b0000, 4'b0000, 4'd0, 4'd0, 0, 2'd0, 2'b00, 0, 0, 0});
        tbl.push_back(vec_t'{1, 12'h001, 0, 0, 4'b0001, 4'b0000, 4'd1, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h001, 0, 0, 4'b0001, 4'b0000, 4'd2, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h001, 0, 0, 4'b0001, 4'b0000, 4'd3, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h001, 0, 0, 4'b0001, 4'b0000, 4'd4, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{1, 12'h200, 0, 1, 4'b1001, 4'b0000, 4'd5, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b1001, 4'b0000, 4'd5, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b1001, 4'b0000, 4'd5, 4'd0, 1, 2'd0, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b1001, 4'b0000, 4'd5, 4'd0, 1, 2'd3, 2'b01, 0, 0, 1});
        tbl.push_back(vec_t'{0, 12'h000, 0, 1, 4'b1001, 4'b0000, 4'd5, 4'd0, 0, 2'd0, 2'b00, 0, 0, 1});

        model_reset();
        repeat (2) @(negedge clock);
        check_model();
        reset = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].en, tbl[i].fire, tbl[i].clr, tbl[i].rdy);
            chk($sformatf("v%0d.sticky_fail", i),  32'(sticky_fail),  32'(tbl[i].sf));
            chk($sformatf("v%0d.sticky_xfail", i), 32'(sticky_xfail), 32'(tbl[i].sxf));
            chk($sformatf("v%0d.fail_count", i),   32'(fail_count),   32'(tbl[i].fc));
            chk($sformatf("v%0d.cover_count", i),  32'(cover_count),  32'(tbl[i].cc));
            chk($sformatf("v%0d.evt_valid", i),    32'(evt_valid),    32'(tbl[i].v));
            chk($sformatf("v%0d.evt_index", i),    32'(evt_index),    32'(tbl[i].idx));
            chk($sformatf("v%0d.evt_type", i),     32'(evt_type),     32'(tbl[i].typ));
            chk($sformatf("v%0d.evt_multi", i),    32'(evt_multi),    32'(tbl[i].mul));
            chk($sformatf("v%0d.overflow", i),     32'(overflow),     32'(tbl[i].ovf));
            chk($sformatf("v%0d.irq", i),          32'(irq),          32'(tbl[i].irq));
        end

        // Cover saturation, then a clear that coincides with a failure.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 12'h020, 1'b0, 1'b0);
            check_model();
        end
        chk("cover_saturated", 32'(cover_count), CMAX);
        cycle(1'b1, 12'h001, 1'b1, 1'b1);
        chk("clr.sticky_fail", 32'(sticky_fail), 0);
        chk("clr.fail_count",  32'(fail_count),  0);
        chk("clr.cover_count", 32'(cover_count), 0);
        chk("clr.evt_valid",   32'(evt_valid),   0);
        chk("clr.irq",         32'(irq),         0);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 12'($urandom & $urandom & $urandom),
                  ($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1);
            check_model();
        end

        // Asynchronous reset while draining three queued events.
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        cycle(1'b1, 12'h001, 1'b0, 1'b0);
        cycle(1'b1, 12'h008, 1'b0, 1'b0);
        cycle(1'b1, 12'h040, 1'b0, 1'b0);
        check_model();
`ifdef OVL_FIRE_COLLECTOR_TIMESTAMP_EN
        chk("ts.first_event", 32'(evt_time), 0);
`endif
        cycle(1'b0, 12'h000, 1'b0, 1'b1);
        check_model();
        #2 reset = 1'b0;
        #1;
        chk("rst.evt_valid",   32'(evt_valid),   0);
        chk("rst.fail_count",  32'(fail_count),  0);
        chk("rst.sticky_fail", 32'(sticky_fail), 0);
        chk("rst.irq",         32'(irq),         0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        cycle(1'b0, 12'h000, 1'b0, 1'b1);
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
